// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding, default settle
// time and the vector/counter widths. Imported by the RTL and by the bench.
package truth_table_sweeper_pkg;

  // Settle cycles held per input vector before sampling; legal range 1..15.
  localparam int unsigned SETTLE_DEFAULT = 2;

  // Three block inputs give eight vectors, so the index is 3 bits wide.
  localparam int unsigned IDX_W = 3;
  localparam int unsigned NUM_VECTORS = 8;

  // Four bits hold any legal settle count, including the one-past-terminal value
  // reached on the final settle cycle.
  localparam int unsigned CNT_W = 4;

  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(NUM_VECTORS - 1);

  // Sweep FSM, 4 states in 2 bits.
  typedef logic [1:0] state_t;
  localparam state_t StIdle   = 2'd0;
  localparam state_t StSettle = 2'd1;
  localparam state_t StSample = 2'd2;
  localparam state_t StDone   = 2'd3;

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Settle counter for the truth-table sweeper. Counts the cycles a vector has been held
// and flags the last settle cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset, clears the count
//   clear     synchronous clear to zero (wins over enable)
//   enable    increment the count this cycle
//   terminal  count == SETTLE-1
module truth_table_sweeper_settle_counter
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == LastCount);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all eight input combinations of a 3-input combinational
// block, holds each for SETTLE+1 cycles, samples the block output on the last of those
// cycles and builds its truth table, then compares it against a golden table.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      sweep request, only sampled while idle
//   expected   golden truth table (bit i for vector i), latched on accepted start
//   u_in       output of the block under sweep
//   c_out      block input c = index bit 2
//   t_out      block input t = index bit 1
//   y_out      block input y = index bit 0
//   busy       high from the cycle after accepted start through the done cycle
//   done       one-cycle completion pulse
//   table_out  captured truth table, bit i = u_in sampled for vector i
//   mismatch   table_out ^ latched expected
//   valid      table_out/mismatch hold a completed sweep
//   pass       valid and no mismatching bit
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       u_in,
  output logic       c_out,
  output logic       t_out,
  output logic       y_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [7:0] mismatch,
  output logic       valid,
  output logic       pass
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] drive_q, drive_d;
  logic [7:0]       table_q, table_d;
  logic [7:0]       exp_q, exp_d;
  logic             valid_q, valid_d;

  logic accept;
  logic settle_clear;
  logic settle_enable;
  logic settle_terminal;

  assign accept = (state_q == StIdle) && start;

  // Count restarts for every vector: on the accepted start and on each sample cycle.
  assign settle_clear  = accept || (state_q == StSample);
  assign settle_enable = (state_q == StSettle);

  truth_table_sweeper_settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (settle_clear),
    .enable   (settle_enable),
    .terminal (settle_terminal)
  );

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    table_d = table_q;
    exp_d   = exp_q;
    valid_d = valid_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
          index_d = '0;
          exp_d   = expected;
          table_d = '0;
          valid_d = 1'b0;
        end
      end
      StSettle: begin
        if (settle_terminal) begin
          state_d = StSample;
        end
      end
      StSample: begin
        table_d[index_q] = u_in;
        // Index stops at the last vector rather than wrapping.
        if (index_q == LAST_INDEX) begin
          state_d = StDone;
        end else begin
          index_d = index_q + IDX_W'(1);
          state_d = StSettle;
        end
      end
      StDone: begin
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Block inputs are registered copies of the index while the sweep is active, so they
  // change on the same edge as the index and the vector gets the full settle window.
  assign drive_d = (state_d == StIdle) ? '0 : index_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      index_q <= '0;
      drive_q <= '0;
      table_q <= '0;
      exp_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      drive_q <= drive_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      valid_q <= valid_d;
    end
  end

  assign c_out     = drive_q[2];
  assign t_out     = drive_q[1];
  assign y_out     = drive_q[0];
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign table_out = table_q;
  assign mismatch  = table_q ^ exp_q;
  assign valid     = valid_q;
  assign pass      = valid_q && (mismatch == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper. Two instances: A with the default settle time driving a
// combinational block, B with SETTLE=1 driving a block that can respond one cycle late.
// Stimulus pushes one expected sweep per accepted start; per-instance monitors pop and
// compare as the DUT reaches done.
module tb_truth_table_sweeper;
  import truth_table_sweeper_pkg::*;

  localparam int unsigned SA    = SETTLE_DEFAULT;
  localparam int unsigned SB    = 1;
  localparam int unsigned LEN_A = 8 * (SA + 1) + 1;
  localparam int unsigned LEN_B = 8 * (SB + 1) + 1;

  typedef struct {
    logic [7:0]  fn;
    logic [7:0]  ex;
    int unsigned ref_cyc;
  } sweep_t;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned cyc     = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: combinational block.
  logic       start_a = 1'b0;
  logic [7:0] exp_a   = 8'h00;
  logic [7:0] fn_a    = 8'h00;
  logic       u_a;
  logic       c_a, t_a, y_a, busy_a, done_a, valid_a, pass_a;
  logic [7:0] tab_a, mis_a;
  assign u_a = fn_a[{c_a, t_a, y_a}];

  // Instance B: block output optionally delayed by one cycle.
  logic       start_b = 1'b0;
  logic [7:0] exp_b   = 8'h00;
  logic [7:0] fn_b    = 8'h00;
  logic       dly_b   = 1'b0;
  logic       u_b_q   = 1'b0;
  logic       u_b;
  logic       c_b, t_b, y_b, busy_b, done_b, valid_b, pass_b;
  logic [7:0] tab_b, mis_b;
  always @(posedge clk) u_b_q <= fn_b[{c_b, t_b, y_b}];
  assign u_b = dly_b ? u_b_q : fn_b[{c_b, t_b, y_b}];

  truth_table_sweeper #(.SETTLE(SA)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .expected(exp_a), .u_in(u_a),
    .c_out(c_a), .t_out(t_a), .y_out(y_a), .busy(busy_a), .done(done_a),
    .table_out(tab_a), .mismatch(mis_a), .valid(valid_a), .pass(pass_a)
  );

  truth_table_sweeper #(.SETTLE(SB)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .expected(exp_b), .u_in(u_b),
    .c_out(c_b), .t_out(t_b), .y_out(y_b), .busy(busy_b), .done(done_b),
    .table_out(tab_b), .mismatch(mis_b), .valid(valid_b), .pass(pass_b)
  );

  sweep_t q_a[$];
  sweep_t q_b[$];
  sweep_t pend_a, pend_b;
  logic   pend_a_v = 1'b0;
  logic   pend_b_v = 1'b0;
  logic   fin_a, fin_b;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %02h, want %02h (cycle %0d)", name, act, req, cyc);
  endtask

  // k = cycles since the start edge. Sweep occupies cycles 1..len, done on cycle len,
  // vector v driven for cycles v*(settle+1)+1 .. (v+1)*(settle+1).
  task automatic cycle_check(input string nm, input int unsigned settle, input logic have,
                             input int unsigned k, input logic busy, input logic done,
                             input logic valid, input logic pass, input logic [2:0] vec,
                             output logic finished);
    int unsigned len;
    logic        bexp;
    logic [2:0]  vexp;
    len  = 8 * (settle + 1) + 1;
    bexp = have && (k >= 1) && (k <= len);
    vexp = 3'd0;
    if (bexp) vexp = (k == len) ? 3'd7 : 3'((k - 1) / (settle + 1));
    chk({nm, " busy"}, {7'd0, busy}, {7'd0, bexp});
    chk({nm, " vector"}, {5'd0, vec}, {5'd0, vexp});
    chk({nm, " done"}, {7'd0, done}, {7'd0, bexp && (k == len)});
    if (bexp) chk({nm, " valid/pass during sweep"}, {6'd0, valid, pass}, 8'd0);
    finished = have && (k >= len);
  endtask

  task automatic result_check(input string nm, input sweep_t s, input logic valid,
                              input logic pass, input logic [7:0] tab, input logic [7:0] mis);
    chk({nm, " valid"}, {7'd0, valid}, 8'd1);
    chk({nm, " table_out"}, tab, s.fn);
    chk({nm, " mismatch"}, mis, s.fn ^ s.ex);
    chk({nm, " pass"}, {7'd0, pass}, {7'd0, s.fn == s.ex});
  endtask

  always @(posedge clk) begin
    #1;
    if (pend_a_v) begin
      result_check("A", pend_a, valid_a, pass_a, tab_a, mis_a);
      pend_a_v = 1'b0;
    end
    if (q_a.size() > 0) begin
      cycle_check("A", SA, 1'b1, cyc - q_a[0].ref_cyc, busy_a, done_a, valid_a, pass_a,
                  {c_a, t_a, y_a}, fin_a);
      if (fin_a) begin
        pend_a   = q_a.pop_front();
        pend_a_v = 1'b1;
      end
    end else begin
      cycle_check("A", SA, 1'b0, 0, busy_a, done_a, valid_a, pass_a, {c_a, t_a, y_a}, fin_a);
    end
  end

  always @(posedge clk) begin
    #1;
    if (pend_b_v) begin
      result_check("B", pend_b, valid_b, pass_b, tab_b, mis_b);
      pend_b_v = 1'b0;
    end
    if (q_b.size() > 0) begin
      cycle_check("B", SB, 1'b1, cyc - q_b[0].ref_cyc, busy_b, done_b, valid_b, pass_b,
                  {c_b, t_b, y_b}, fin_b);
      if (fin_b) begin
        pend_b   = q_b.pop_front();
        pend_b_v = 1'b1;
      end
    end else begin
      cycle_check("B", SB, 1'b0, 0, busy_b, done_b, valid_b, pass_b, {c_b, t_b, y_b}, fin_b);
    end
  end

  // One-cycle start pulse on A; the golden input is scrambled afterwards because only the
  // value present at the accepted start may matter.
  task automatic launch_a(input logic [7:0] fn, input logic [7:0] ex, output int unsigned r);
    @(negedge clk);
    fn_a    = fn;
    exp_a   = ex;
    start_a = 1'b1;
    r       = cyc;
    q_a.push_back('{fn, ex, r});
    @(negedge clk);
    start_a = 1'b0;
    exp_a   = 8'($urandom);
  endtask

  task automatic launch_b(input logic [7:0] fn, input logic [7:0] ex, input logic dly);
    @(negedge clk);
    fn_b    = fn;
    exp_b   = ex;
    dly_b   = dly;
    start_b = 1'b1;
    q_b.push_back('{fn, ex, cyc});
    @(negedge clk);
    start_b = 1'b0;
    exp_b   = 8'($urandom);
  endtask

  task automatic check_outputs_zero(input string nm, input logic busy, input logic done,
                                    input logic [2:0] vec, input logic [7:0] tab,
                                    input logic [7:0] mis, input logic valid, input logic pass);
    chk({nm, " busy/done"}, {6'd0, busy, done}, 8'd0);
    chk({nm, " c/t/y"}, {5'd0, vec}, 8'd0);
    chk({nm, " table_out"}, tab, 8'd0);
    chk({nm, " mismatch"}, mis, 8'd0);
    chk({nm, " valid/pass"}, {6'd0, valid, pass}, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r;
    logic [7:0]  fn, ex;

    repeat (2) @(negedge clk);
    check_outputs_zero("reset A", busy_a, done_a, {c_a, t_a, y_a}, tab_a, mis_a, valid_a,
                       pass_a);
    check_outputs_zero("reset B", busy_b, done_b, {c_b, t_b, y_b}, tab_b, mis_b, valid_b,
                       pass_b);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Majority block against its own table, then XOR3 against the majority table.
    launch_a(8'hE8, 8'hE8, r);
    repeat (LEN_A + 1) @(negedge clk);
    launch_a(8'h96, 8'hE8, r);
    repeat (LEN_A + 1) @(negedge clk);
    // Results hold while idle.
    repeat (5) @(negedge clk);
    chk("A hold table_out", tab_a, 8'h96);
    chk("A hold mismatch", mis_a, 8'h7E);
    chk("A hold valid", {7'd0, valid_a}, 8'd1);

    // Random blocks and golden tables.
    for (int i = 0; i < 4; i++) begin
      fn = 8'($urandom);
      ex = ($urandom_range(0, 1) == 1) ? fn : 8'($urandom);
      launch_a(fn, ex, r);
      repeat (LEN_A + 1 + $urandom_range(0, 3)) @(negedge clk);
    end

    // start re-pulsed in cycles 5 and 20 of a sweep is ignored.
    launch_a(8'($urandom), 8'($urandom), r);
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (14) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (LEN_A - 18) @(negedge clk);

    // Reset in cycle 10 abandons the sweep; a fresh sweep then runs from vector 000.
    launch_a(8'($urandom), 8'($urandom), r);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    q_a.delete();
    q_b.delete();
    pend_a_v = 1'b0;
    pend_b_v = 1'b0;
    #1;
    check_outputs_zero("mid-sweep reset A", busy_a, done_a, {c_a, t_a, y_a}, tab_a, mis_a,
                       valid_a, pass_a);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    launch_a(8'hE8, 8'hE8, r);
    repeat (LEN_A + 1) @(negedge clk);

    // B: start held high for 60 cycles with a late-responding block.
    @(negedge clk);
    fn      = 8'($urandom);
    ex      = 8'($urandom);
    fn_b    = fn;
    exp_b   = ex;
    dly_b   = 1'b1;
    start_b = 1'b1;
    r       = cyc;
    for (int s = 0; s < 60; s += LEN_B + 1) q_b.push_back('{fn, ex, r + s});
    repeat (60) @(negedge clk);
    start_b = 1'b0;
    repeat (LEN_B + 4) @(negedge clk);

    // B: single sweeps, delayed and immediate blocks.
    for (int i = 0; i < 4; i++) begin
      fn = 8'($urandom);
      ex = ($urandom_range(0, 1) == 1) ? fn : 8'($urandom);
      launch_b(fn, ex, 1'($urandom_range(0, 1)));
      repeat (LEN_B + 2) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE, default 2, meaning the number of settle cycles held per input vector before sampling (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  sweep request, sampled in IDLE only.
REQ-005 expected  input  8  golden truth table, bit i = expected output for vector i; latched on accepted start.
REQ-006 u_in  input  1  output of the 3-input combinational block under sweep.
REQ-007 c_out  output  1  drive to block input c, equals index bit 2.
REQ-008 t_out  output  1  drive to block input t, equals index bit 1.
REQ-009 y_out  output  1  drive to block input y, equals index bit 0.
REQ-010 busy  output  1  high from the cycle after accepted start through the DONE cycle.
REQ-011 done  output  1  single-cycle pulse marking sweep completion.
REQ-012 table_out  output  8  captured truth table, bit i = u_in sampled for vector i.
REQ-013 mismatch  output  8  table_out XOR latched expected.
REQ-014 valid  output  1  table_out/mismatch hold a completed sweep.
REQ-015 pass  output  1  valid AND mismatch == 0.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-017 IDLE with start=1: index <= 0, settle count <= 0, expected latched, table_out <= 0, valid <= 0, go to SETTLE.
REQ-018 SETTLE: count increments each cycle; when count == SETTLE-1, go to SAMPLE.
REQ-019 SAMPLE: table_out[index] <= u_in; if index == 7 go to DONE, else index += 1, count <= 0, go to SETTLE.
REQ-020 DONE: done = 1 for exactly this cycle, valid <= 1 at the exiting edge, go to IDLE.
REQ-021 Each vector SHALL be driven for SETTLE+1 cycles; done SHALL be high in cycle 8*(SETTLE+1)+1 after the start edge (25 for SETTLE=2).
REQ-022 c_out/t_out/y_out SHALL be registered index bits while busy, 000 in IDLE; index SHALL not wrap past 7.
REQ-023 start while busy SHALL be ignored; start held high in IDLE SHALL launch back-to-back sweeps, the next accepted in the IDLE cycle after DONE.
REQ-024 table_out, mismatch, valid, pass SHALL hold after DONE until the next accepted start clears valid and table_out.
REQ-025 mismatch and pass SHALL be combinational from table_out, latched expected, and valid; pass = 0 whenever valid = 0.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, index 0, count 0, c/t/y_out 0, busy 0, done 0, table_out 0, latched expected 0, valid 0.
REQ-027 reset_n asserted mid-sweep SHALL abandon the sweep with no done pulse; first start after release begins a fresh sweep at vector 000.

Structure
REQ-028 The state encoding (4 states, 2 bits) and the default SETTLE value SHALL live in a shared package used by RTL and bench.
REQ-029 The settle counter SHALL be one sub-module, settle_counter (clear, enable, terminal-count output).

Verification
REQ-030 Majority-function block, expected=8'hE8, SETTLE=2, start pulse -> c/t/y step 000..111, each held 3 cycles; done in cycle 25; table_out=8'hE8, mismatch=0, pass=1.
REQ-031 XOR3 block (true table 8'h96), expected=8'hE8 -> table_out=8'h96, mismatch=8'h7E, pass=0, valid=1.
REQ-032 start re-pulsed at cycles 5 and 20 of a sweep -> ignored; done still in cycle 25 only.
REQ-033 reset_n low at cycle 10 of a sweep -> outputs zero immediately, no done; new start -> full 25-cycle sweep from 000.
REQ-034 start held high for 60 cycles, SETTLE=1 -> done pulses at cycles 17 and 35, busy low for exactly one cycle between sweeps.
REQ-035 SETTLE=1, block output u_in that changes one cycle after the inputs change (delayed model) -> the sample for each vector reflects its own value, with no vector offset.
